// File: rtl/f_alu_issue_if.sv
// Request/response and ALU-side bundle for the FP ALU issue sequencer.
// master: the CPU/ALU environment; slave: the sequencer itself.
interface f_alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic [31:0] in_op3;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [31:0] alu_data3;
    logic [5:0]  alu_select;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_illegal;

    modport master (
        output in_valid, in_instr, in_op1, in_op2, in_op3, out_ready, alu_result,
        input  in_ready, out_valid, out_result, out_illegal,
               alu_data1, alu_data2, alu_data3, alu_select
    );

    modport slave (
        input  in_valid, in_instr, in_op1, in_op2, in_op3, out_ready, alu_result,
        output in_ready, out_valid, out_result, out_illegal,
               alu_data1, alu_data2, alu_data3, alu_select
    );
endinterface

// File: rtl/f_alu_issue.sv
// Single-precision FP ALU sequencer: decodes an RV32F instruction into the
// ALU select code, holds operands for the operation's latency, captures the
// ALU result and returns it with an illegal-op flag over valid/ready.
module f_alu_issue #(
    parameter int LAT_BASIC = 1,
    parameter int LAT_DIV   = 16,
    parameter int LAT_SQRT  = 16,
    parameter int LAT_FMA   = 2
) (
    input  logic          clk,
    input  logic          reset,
    f_alu_issue_if.slave  bus
);

    localparam logic [5:0] SEL_FADD   = 6'b000000;
    localparam logic [5:0] SEL_FSUB   = 6'b000001;
    localparam logic [5:0] SEL_FMUL   = 6'b000010;
    localparam logic [5:0] SEL_FDIV   = 6'b000011;
    localparam logic [5:0] SEL_FSQRT  = 6'b000100;
    localparam logic [5:0] SEL_FMIN   = 6'b000101;
    localparam logic [5:0] SEL_FMAX   = 6'b000110;
    localparam logic [5:0] SEL_FMADD  = 6'b001000;
    localparam logic [5:0] SEL_FMSUB  = 6'b001001;
    localparam logic [5:0] SEL_FNMADD = 6'b001010;
    localparam logic [5:0] SEL_FNMSUB = 6'b001011;
    localparam logic [5:0] SEL_NONE   = 6'b111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter preload is latency-1; a latency of 0 behaves like 1.
    function automatic logic [4:0] lat_load(input int lat);
        logic [4:0] v;
        if (lat <= 1) begin
            v = 5'd0;
        end else begin
            v = 5'(lat - 1);
        end
        return v;
    endfunction

    localparam logic [4:0] LOAD_BASIC = lat_load(LAT_BASIC);
    localparam logic [4:0] LOAD_DIV   = lat_load(LAT_DIV);
    localparam logic [4:0] LOAD_SQRT  = lat_load(LAT_SQRT);
    localparam logic [4:0] LOAD_FMA   = lat_load(LAT_FMA);

    // Returns {legal, select}; the rounding-mode field only matters for FMIN/FMAX
    // where funct3 distinguishes the two operations.
    function automatic logic [6:0] decode(input logic [31:0] instr);
        logic [6:0] opcode;
        logic [4:0] funct5;
        logic [1:0] fmt;
        logic [2:0] funct3;
        logic [4:0] rs2;
        logic [6:0] dec;
        opcode = instr[6:0];
        funct5 = instr[31:27];
        fmt    = instr[26:25];
        funct3 = instr[14:12];
        rs2    = instr[24:20];
        dec    = {1'b0, SEL_NONE};
        case (opcode)
            7'b1010011: begin
                if (fmt == 2'b00) begin
                    case (funct5)
                        5'b00000: dec = {1'b1, SEL_FADD};
                        5'b00001: dec = {1'b1, SEL_FSUB};
                        5'b00010: dec = {1'b1, SEL_FMUL};
                        5'b00011: dec = {1'b1, SEL_FDIV};
                        5'b01011: begin
                            if (rs2 == 5'd0) begin
                                dec = {1'b1, SEL_FSQRT};
                            end else begin
                                dec = {1'b0, SEL_NONE};
                            end
                        end
                        5'b00101: begin
                            case (funct3)
                                3'b000:  dec = {1'b1, SEL_FMIN};
                                3'b001:  dec = {1'b1, SEL_FMAX};
                                default: dec = {1'b0, SEL_NONE};
                            endcase
                        end
                        default: dec = {1'b0, SEL_NONE};
                    endcase
                end else begin
                    dec = {1'b0, SEL_NONE};
                end
            end
            7'b1000011: dec = (fmt == 2'b00) ? {1'b1, SEL_FMADD}  : {1'b0, SEL_NONE};
            7'b1000111: dec = (fmt == 2'b00) ? {1'b1, SEL_FMSUB}  : {1'b0, SEL_NONE};
            7'b1001111: dec = (fmt == 2'b00) ? {1'b1, SEL_FNMADD} : {1'b0, SEL_NONE};
            7'b1001011: dec = (fmt == 2'b00) ? {1'b1, SEL_FNMSUB} : {1'b0, SEL_NONE};
            default:    dec = {1'b0, SEL_NONE};
        endcase
        return dec;
    endfunction

    // Counter preload for a decoded select code.
    function automatic logic [4:0] load_for(input logic [5:0] code);
        logic [4:0] v;
        case (code)
            SEL_FDIV:   v = LOAD_DIV;
            SEL_FSQRT:  v = LOAD_SQRT;
            SEL_FMADD,
            SEL_FMSUB,
            SEL_FNMADD,
            SEL_FNMSUB: v = LOAD_FMA;
            default:    v = LOAD_BASIC;
        endcase
        return v;
    endfunction

    state_t      state_r, state_s;
    logic [4:0]  cnt_r, cnt_s;
    logic [5:0]  code_r, code_s;
    logic [5:0]  sel_r, sel_s;
    logic [31:0] data1_r, data1_s;
    logic [31:0] data2_r, data2_s;
    logic [31:0] data3_r, data3_s;
    logic [31:0] result_r, result_s;
    logic        illegal_r, illegal_s;
    logic        in_ready_r, in_ready_s;
    logic        out_valid_r, out_valid_s;
    logic [6:0]  dec_s;

    assign dec_s = decode(bus.in_instr);

    // Next-state and next-output logic; the select register is armed on entry
    // to EXEC and dropped back to SEL_NONE on the final EXEC cycle.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        code_s      = code_r;
        sel_s       = SEL_NONE;
        data1_s     = data1_r;
        data2_s     = data2_r;
        data3_s     = data3_r;
        result_s    = result_r;
        illegal_s   = illegal_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    data1_s = bus.in_op1;
                    data2_s = bus.in_op2;
                    data3_s = bus.in_op3;
                    if (dec_s[6]) begin
                        state_s = EXEC;
                        code_s  = dec_s[5:0];
                        sel_s   = dec_s[5:0];
                        cnt_s   = load_for(dec_s[5:0]);
                    end else begin
                        state_s   = DONE;
                        result_s  = 32'd0;
                        illegal_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == 5'd0) begin
                    result_s  = bus.alu_result;
                    illegal_s = 1'b0;
                    state_s   = DONE;
                    sel_s     = SEL_NONE;
                end else begin
                    cnt_s = cnt_r - 5'd1;
                    sel_s = code_r;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 5'd0;
            end
        endcase
        in_ready_s  = (state_s == IDLE);
        out_valid_s = (state_s == DONE);
    end

    // State and output registers with synchronous reset; reset drops any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 5'd0;
            code_r      <= SEL_NONE;
            sel_r       <= SEL_NONE;
            data1_r     <= 32'd0;
            data2_r     <= 32'd0;
            data3_r     <= 32'd0;
            result_r    <= 32'd0;
            illegal_r   <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            code_r      <= code_s;
            sel_r       <= sel_s;
            data1_r     <= data1_s;
            data2_r     <= data2_s;
            data3_r     <= data3_s;
            result_r    <= result_s;
            illegal_r   <= illegal_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_result  = result_r;
    assign bus.out_illegal = illegal_r;
    assign bus.alu_select  = sel_r;
    assign bus.alu_data1   = data1_r;
    assign bus.alu_data2   = data2_r;
    assign bus.alu_data3   = data3_r;

endmodule

// File: tb/tb_f_alu_issue.sv
// Scoreboard bench for f_alu_issue: directed RV32F requests push expected
// responses; a monitor pops them when OUT_VALID rises and checks result,
// flag, latency, select duration and hold behaviour.
module tb_f_alu_issue;

    localparam logic [5:0] SEL_FADD   = 6'b000000;
    localparam logic [5:0] SEL_FSUB   = 6'b000001;
    localparam logic [5:0] SEL_FMUL   = 6'b000010;
    localparam logic [5:0] SEL_FDIV   = 6'b000011;
    localparam logic [5:0] SEL_FSQRT  = 6'b000100;
    localparam logic [5:0] SEL_FMIN   = 6'b000101;
    localparam logic [5:0] SEL_FMAX   = 6'b000110;
    localparam logic [5:0] SEL_FMADD  = 6'b001000;
    localparam logic [5:0] SEL_FMSUB  = 6'b001001;
    localparam logic [5:0] SEL_FNMADD = 6'b001010;
    localparam logic [5:0] SEL_FNMSUB = 6'b001011;
    localparam logic [5:0] SEL_NONE   = 6'b111111;

    logic clk;
    logic reset;
    int   cyc;
    int   n_vec;
    int   n_fail;

    f_alu_issue_if bus ();

    f_alu_issue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        ill;
        logic [5:0]  code;
        int          lat;
        int          acc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } exp_t;

    exp_t q[$];

    // Stand-in ALU: hand-computed IEEE results for the operand sets used here.
    function automatic logic [31:0] alu_model(input logic [5:0] s, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c);
        logic [31:0] r;
        r = 32'hBAD0_0000 | {26'd0, s};
        case (s)
            SEL_FADD:   if (a == 32'h3F80_0000 && b == 32'h4000_0000) r = 32'h4040_0000;
            SEL_FSUB:   if (a == 32'h4000_0000 && b == 32'h3F80_0000) r = 32'h3F80_0000;
            SEL_FMUL:   if (a == 32'h4000_0000 && b == 32'h4040_0000) r = 32'h40C0_0000;
            SEL_FDIV:   if (a == 32'h40C0_0000 && b == 32'h4000_0000) r = 32'h4040_0000;
            SEL_FSQRT:  if (a == 32'h4080_0000) r = 32'h4000_0000;
            SEL_FMIN:   if (a == 32'hBF80_0000 && b == 32'h3F80_0000) r = 32'hBF80_0000;
            SEL_FMAX:   if (a == 32'hBF80_0000 && b == 32'h3F80_0000) r = 32'h3F80_0000;
            SEL_FMADD:  if (a == 32'h3F80_0000 && b == 32'h4000_0000 && c == 32'h3F80_0000) r = 32'h4040_0000;
            SEL_FMSUB:  if (a == 32'h4040_0000 && b == 32'h4000_0000 && c == 32'h3F80_0000) r = 32'h40A0_0000;
            SEL_FNMADD: if (a == 32'h3F80_0000 && b == 32'h4000_0000 && c == 32'h3F80_0000) r = 32'hC040_0000;
            SEL_FNMSUB: if (a == 32'h3F80_0000 && b == 32'h3F80_0000 && c == 32'h4000_0000) r = 32'h3F80_0000;
            SEL_NONE:   r = 32'd0;
            default:    r = 32'hBAD0_0000 | {26'd0, s};
        endcase
        return r;
    endfunction

    assign bus.alu_result = alu_model(bus.alu_select, bus.alu_data1, bus.alu_data2, bus.alu_data3);

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2, input logic [2:0] f3);
        return {f7, rs2, 5'd1, f3, 5'd1, 7'b1010011};
    endfunction

    function automatic logic [31:0] r4type(input logic [6:0] opc, input logic [1:0] fmt);
        return {5'd3, fmt, 5'd2, 5'd1, 3'b000, 5'd1, opc};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input string nm, input logic [31:0] instr,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic ill, input logic [5:0] code, input int lat,
                         input logic [31:0] res, input bit push);
        int   t;
        bit   done;
        exp_t e;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_op1   = a;
        bus.in_op2   = b;
        bus.in_op3   = c;
        t    = 0;
        done = 1'b0;
        while (!done && t < 100) begin
            @(negedge clk);
            if (bus.in_ready) begin
                done = 1'b1;
                if (push) begin
                    e.name = nm;  e.res = res;  e.ill = ill;  e.code = code;
                    e.lat  = lat; e.acc = cyc;  e.a = a;      e.b = b;  e.c = c;
                    q.push_back(e);
                end
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
            end else begin
                t = t + 1;
            end
        end
        if (!done) begin
            n_vec  = n_vec + 1;
            n_fail = n_fail + 1;
            $display("FAIL %s accept: in_ready stayed 0, expected 1 within 100 cycles", nm);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t = t + 1;
        end
        n_vec = n_vec + 1;
        if (q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: pops an expectation on each new OUT_VALID episode and checks it.
    initial begin
        exp_t cur;
        bit   have_cur;
        int   sel_cnt;
        have_cur = 1'b0;
        sel_cnt  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                have_cur = 1'b0;
                sel_cnt  = 0;
            end else begin
                if (bus.alu_select != SEL_NONE) begin
                    sel_cnt = sel_cnt + 1;
                    if (q.size() > 0) begin
                        chk({q[0].name, " select"}, {26'd0, bus.alu_select}, {26'd0, q[0].code});
                        chk({q[0].name, " data1"}, bus.alu_data1, q[0].a);
                        chk({q[0].name, " data2"}, bus.alu_data2, q[0].b);
                        chk({q[0].name, " data3"}, bus.alu_data3, q[0].c);
                    end
                end
                if (bus.out_valid) begin
                    if (!have_cur) begin
                        if (q.size() == 0) begin
                            n_vec  = n_vec + 1;
                            n_fail = n_fail + 1;
                            $display("FAIL unexpected out_valid: result %h, expected no response", bus.out_result);
                        end else begin
                            cur      = q.pop_front();
                            have_cur = 1'b1;
                            chk({cur.name, " latency"}, 32'(cyc), 32'(cur.acc + (cur.ill ? 1 : cur.lat + 1)));
                            chk({cur.name, " select cycles"}, 32'(sel_cnt), 32'(cur.ill ? 0 : cur.lat));
                            sel_cnt = 0;
                        end
                    end
                    if (have_cur) begin
                        chk({cur.name, " result"}, bus.out_result, cur.res);
                        chk({cur.name, " illegal"}, 32'(bus.out_illegal), 32'(cur.ill));
                        chk({cur.name, " in_ready in DONE"}, 32'(bus.in_ready), 32'd0);
                        if (bus.out_ready) begin
                            have_cur = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int t;
        n_vec         = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.in_op1    = 32'd0;
        bus.in_op2    = 32'd0;
        bus.in_op3    = 32'd0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out_result", bus.out_result, 32'd0);
        chk("reset out_illegal", 32'(bus.out_illegal), 32'd0);
        chk("reset alu_select", {26'd0, bus.alu_select}, {26'd0, SEL_NONE});
        chk("reset alu_data1", bus.alu_data1, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        issue("FADD", 32'h0020_8053, 32'h3F80_0000, 32'h4000_0000, 32'd0, 1'b0, SEL_FADD, 1, 32'h4040_0000, 1'b1);
        drain();
        issue("FADD rm=dyn", rtype(7'b0000000, 5'd2, 3'b111), 32'h3F80_0000, 32'h4000_0000, 32'd0, 1'b0, SEL_FADD, 1, 32'h4040_0000, 1'b1);
        drain();
        issue("FSUB", rtype(7'b0000100, 5'd2, 3'b000), 32'h4000_0000, 32'h3F80_0000, 32'd0, 1'b0, SEL_FSUB, 1, 32'h3F80_0000, 1'b1);
        drain();
        issue("FMUL", rtype(7'b0001000, 5'd2, 3'b000), 32'h4000_0000, 32'h4040_0000, 32'd0, 1'b0, SEL_FMUL, 1, 32'h40C0_0000, 1'b1);
        drain();
        issue("FDIV", rtype(7'b0001100, 5'd2, 3'b000), 32'h40C0_0000, 32'h4000_0000, 32'd0, 1'b0, SEL_FDIV, 16, 32'h4040_0000, 1'b1);
        drain();
        issue("FSQRT", rtype(7'b0101100, 5'd0, 3'b000), 32'h4080_0000, 32'd0, 32'd0, 1'b0, SEL_FSQRT, 16, 32'h4000_0000, 1'b1);
        drain();
        issue("FSQRT rs2=1", rtype(7'b0101100, 5'd1, 3'b000), 32'h4080_0000, 32'd0, 32'd0, 1'b1, SEL_NONE, 0, 32'd0, 1'b1);
        drain();
        issue("FADD.D", rtype(7'b0000001, 5'd2, 3'b000), 32'h3F80_0000, 32'h4000_0000, 32'd0, 1'b1, SEL_NONE, 0, 32'd0, 1'b1);
        drain();
        issue("FMINMAX f3=010", rtype(7'b0010100, 5'd2, 3'b010), 32'hBF80_0000, 32'h3F80_0000, 32'd0, 1'b1, SEL_NONE, 0, 32'd0, 1'b1);
        drain();
        issue("FMADD.D", r4type(7'b1000011, 2'b01), 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 1'b1, SEL_NONE, 0, 32'd0, 1'b1);
        drain();
        issue("ADDI", 32'h0000_0013, 32'h3F80_0000, 32'h4000_0000, 32'd0, 1'b1, SEL_NONE, 0, 32'd0, 1'b1);
        drain();
        issue("FMSUB", r4type(7'b1000111, 2'b00), 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000, 1'b0, SEL_FMSUB, 2, 32'h40A0_0000, 1'b1);
        drain();
        issue("FNMADD", r4type(7'b1001111, 2'b00), 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 1'b0, SEL_FNMADD, 2, 32'hC040_0000, 1'b1);
        drain();
        issue("FNMSUB", r4type(7'b1001011, 2'b00), 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, SEL_FNMSUB, 2, 32'h3F80_0000, 1'b1);
        drain();

        // Backpressure: result held for several cycles with OUT_READY low.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        issue("FMADD held", r4type(7'b1000011, 2'b00), 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 1'b0, SEL_FMADD, 2, 32'h4040_0000, 1'b1);
        t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t = t + 1;
        end
        repeat (5) @(negedge clk);
        chk("held out_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release in_ready", 32'(bus.in_ready), 32'd1);
        chk("release out_valid", 32'(bus.out_valid), 32'd0);
        drain();

        // Reset during the eighth FDIV cycle: the op must vanish without a response.
        issue("FDIV aborted", rtype(7'b0001100, 5'd2, 3'b000), 32'h40C0_0000, 32'h4000_0000, 32'd0, 1'b0, SEL_FDIV, 16, 32'h4040_0000, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort alu_select", {26'd0, bus.alu_select}, {26'd0, SEL_NONE});
        chk("abort out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort out_result", bus.out_result, 32'd0);
        repeat (25) @(negedge clk);

        // Back-to-back FMIN then FMAX.
        issue("FMIN", rtype(7'b0010100, 5'd2, 3'b000), 32'hBF80_0000, 32'h3F80_0000, 32'd0, 1'b0, SEL_FMIN, 1, 32'hBF80_0000, 1'b1);
        issue("FMAX", rtype(7'b0010100, 5'd2, 3'b001), 32'hBF80_0000, 32'h3F80_0000, 32'd0, 1'b0, SEL_FMAX, 1, 32'h3F80_0000, 1'b1);
        drain();
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
